// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-port ALU arbiter:
//   - ALU operation codes used by every requester of the shared ALU
//   - port identifiers and the round-robin pointer type
//   - small helpers used by the arbiter sub-module
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    // ALU operation codes
    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_ORI = 3'b010;
    localparam logic [2:0] ALU_OP_LUI = 3'b011;

    // Load-upper-immediate moves the operand into the upper half-word
    localparam int LUI_SHIFT = 16;

    localparam int NUM_PORTS = 2;

    // Identifies one of the two requesters; also the priority pointer type
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // Pointer value after a grant: priority moves to the port not served
    function automatic port_e other_port(input port_e p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/alu_arbiter_arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Two-way arbiter with a 1-bit priority pointer.
//   FAIR = 1 : round-robin, the pointer selects the winner when both request
//   FAIR = 0 : fixed priority, port 0 always wins a contest
// A lone request is granted regardless of the pointer. After a grant the
// pointer moves to the other port; it holds in cycles without a grant.
//
// Ports
//   clk_i   input   clock, rising edge
//   rst_ni  input   synchronous active-low reset (pointer -> PORT0)
//   req_i   input   [1:0] eligible requests
//   gnt_o   output  [1:0] one-hot (or zero) grant, combinational from req_i
// -----------------------------------------------------------------------------
module arb_rr2
    import alu_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_e ptr_q;
    port_e ptr_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            if (FAIR && (ptr_q == PORT1)) begin
                gnt_o = 2'b10;
            end else begin
                gnt_o = 2'b01;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = other_port(PORT0);
        end else if (gnt_o[1]) begin
            ptr_d = other_port(PORT1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two requesters share a single combinational ALU. At most one request is
// accepted per cycle; its result is registered into that port's result slot
// and presented one cycle after the handshake. A slot that is draining in the
// same cycle may be refilled, so each port sustains one result per cycle.
//
// Parameters
//   WIDTH  operand / result width
//   FAIR   1 = round-robin between ports, 0 = fixed priority to port 0
//
// Ports
//   clk                 input   clock, rising edge
//   reset               input   synchronous active-low reset
//   m<i>_valid          input   request present
//   m<i>_ready          output  request accepted this cycle
//   m<i>_a, m<i>_b      input   [WIDTH] operands
//   m<i>_op             input   [3] ALU operation code
//   r<i>_valid          output  result slot holds a result
//   r<i>_ready          input   consumer takes the result
//   r<i>_data           output  [WIDTH] result
//   r<i>_equal          output  (a == b) of the request
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             m0_valid,
    output logic             m0_ready,
    input  logic [WIDTH-1:0] m0_a,
    input  logic [WIDTH-1:0] m0_b,
    input  logic [2:0]       m0_op,

    input  logic             m1_valid,
    output logic             m1_ready,
    input  logic [WIDTH-1:0] m1_a,
    input  logic [WIDTH-1:0] m1_b,
    input  logic [2:0]       m1_op,

    output logic             r0_valid,
    input  logic             r0_ready,
    output logic [WIDTH-1:0] r0_data,
    output logic             r0_equal,

    output logic             r1_valid,
    input  logic             r1_ready,
    output logic [WIDTH-1:0] r1_data,
    output logic             r1_equal
);

    logic [NUM_PORTS-1:0]            elig;
    logic [NUM_PORTS-1:0]            gnt;
    logic [NUM_PORTS-1:0]            acc;
    logic [NUM_PORTS-1:0]            r_ready;

    logic [WIDTH-1:0]                a_sel;
    logic [WIDTH-1:0]                b_sel;
    logic [2:0]                      op_sel;
    logic [WIDTH-1:0]                alu_data;
    logic                            alu_equal;

    logic [NUM_PORTS-1:0]            slot_valid_q;
    logic [NUM_PORTS-1:0]            slot_valid_d;
    logic [NUM_PORTS-1:0][WIDTH-1:0] slot_data_q;
    logic [NUM_PORTS-1:0][WIDTH-1:0] slot_data_d;
    logic [NUM_PORTS-1:0]            slot_eq_q;
    logic [NUM_PORTS-1:0]            slot_eq_d;

    assign r_ready = {r1_ready, r0_ready};

    // A port may compete only if its slot can take a new result at the edge:
    // either it is empty or its consumer empties it this cycle.
    assign elig[0] = m0_valid & (~slot_valid_q[0] | r0_ready);
    assign elig[1] = m1_valid & (~slot_valid_q[1] | r1_ready);

    arb_rr2 #(
        .FAIR   (FAIR)
    ) u_arb (
        .clk_i  (clk),
        .rst_ni (reset),
        .req_i  (elig),
        .gnt_o  (gnt)
    );

    // While reset is low nothing is accepted, so no request can slip through
    // on the edge that clears the slots.
    assign acc      = gnt & {NUM_PORTS{reset}};
    assign m0_ready = acc[0];
    assign m1_ready = acc[1];

    // Operand steering into the shared ALU; port 0 is the idle default
    always_comb begin
        a_sel  = m0_a;
        b_sel  = m0_b;
        op_sel = m0_op;
        if (gnt[1]) begin
            a_sel  = m1_a;
            b_sel  = m1_b;
            op_sel = m1_op;
        end
    end

    // Shared ALU, purely combinational; unknown op codes yield zero
    always_comb begin
        alu_data = '0;
        case (op_sel)
            ALU_OP_ADD: alu_data = a_sel + b_sel;
            ALU_OP_SUB: alu_data = a_sel - b_sel;
            ALU_OP_ORI: alu_data = a_sel | b_sel;
            ALU_OP_LUI: alu_data = b_sel << LUI_SHIFT;
            default:    alu_data = '0;
        endcase
    end

    assign alu_equal = (a_sel == b_sel);

    // Result slots: a new accept wins over a drain in the same cycle; data
    // only changes on an accept, so it holds while the consumer stalls.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        slot_eq_d    = slot_eq_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (acc[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_data_d[i]  = alu_data;
                slot_eq_d[i]    = alu_equal;
            end else if (r_ready[i]) begin
                slot_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_valid_q <= '0;
            slot_data_q  <= '0;
            slot_eq_q    <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            slot_eq_q    <= slot_eq_d;
        end
    end

    assign r0_valid = slot_valid_q[0];
    assign r0_data  = slot_data_q[0];
    assign r0_equal = slot_eq_q[0];
    assign r1_valid = slot_valid_q[1];
    assign r1_data  = slot_data_q[1];
    assign r1_equal = slot_eq_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + randomised bench for alu_arbiter with a per-port result queue.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         m0_valid, m1_valid, m0_ready, m1_ready;
    logic [W-1:0] m0_a, m0_b, m1_a, m1_b;
    logic [2:0]   m0_op, m1_op;
    logic         r0_valid, r1_valid, r0_ready, r1_ready;
    logic [W-1:0] r0_data, r1_data;
    logic         r0_equal, r1_equal;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .FAIR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_a(m0_a), .m0_b(m0_b), .m0_op(m0_op),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_a(m1_a), .m1_b(m1_b), .m1_op(m1_op),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data), .r0_equal(r0_equal),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data), .r1_equal(r1_equal)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         e;
    } res_t;

    res_t q0[$];
    res_t q1[$];
    logic ptr_m = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a | b;
            3'b011:  return {b[15:0], 16'h0000};
            default: return '0;
        endcase
    endfunction

    // Called at the falling edge: compare outputs to the model, then advance
    // the model to the state it will have after the next rising edge.
    task automatic check_cycle();
        logic       e0, e1;
        logic [1:0] g;
        res_t       r;
        e0 = m0_valid && (q0.size() == 0 || r0_ready);
        e1 = m1_valid && (q1.size() == 0 || r1_ready);
        if (e0 && e1) g = ptr_m ? 2'b10 : 2'b01;
        else          g = {e1, e0};
        chk("m0_ready", m0_ready, g[0]);
        chk("m1_ready", m1_ready, g[1]);
        chk("r0_valid", r0_valid, q0.size() != 0);
        chk("r1_valid", r1_valid, q1.size() != 0);
        if (q0.size() != 0) begin
            chk("r0_data", r0_data, q0[0].d);
            chk("r0_equal", r0_equal, q0[0].e);
        end
        if (q1.size() != 0) begin
            chk("r1_data", r1_data, q1[0].d);
            chk("r1_equal", r1_equal, q1[0].e);
        end
        if (r0_ready && q0.size() != 0) void'(q0.pop_front());
        if (r1_ready && q1.size() != 0) void'(q1.pop_front());
        if (g[0]) begin
            r.d = ref_alu(m0_op, m0_a, m0_b);
            r.e = (m0_a == m0_b);
            q0.push_back(r);
        end
        if (g[1]) begin
            r.d = ref_alu(m1_op, m1_a, m1_b);
            r.e = (m1_a == m1_b);
            q1.push_back(r);
        end
        if (g[0])      ptr_m = 1'b1;
        else if (g[1]) ptr_m = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        adv();
    endtask

    task automatic set_m0(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        m0_valid = v; m0_op = op; m0_a = a; m0_b = b;
    endtask

    task automatic set_m1(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        m1_valid = v; m1_op = op; m1_a = a; m1_b = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held low three cycles with both requesters active
        reset = 1'b0;
        set_m0(1'b1, 3'b000, 32'h1, 32'h2);
        set_m1(1'b1, 3'b000, 32'h3, 32'h4);
        r0_ready = 1'b1;
        r1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_m0_ready", m0_ready, 1'b0);
            chk("rst_m1_ready", m1_ready, 1'b0);
            chk("rst_r0_valid", r0_valid, 1'b0);
            chk("rst_r1_valid", r1_valid, 1'b0);
            chk("rst_r0_data", r0_data, 32'h0);
            chk("rst_r1_data", r1_data, 32'h0);
        end
        adv();
        reset = 1'b1;
        ptr_m = 1'b0;

        // Both ports valid every cycle: grants alternate starting with port 0
        for (int i = 0; i < 6; i++) begin
            set_m0(1'b1, 3'(i % 4), 32'(i * 7 + 3), 32'(i));
            set_m1(1'b1, 3'((i + 1) % 4), 32'(i * 5), 32'(i * 5));
            tick();
            chk("rr_grant0", m0_ready, (i % 2) == 0);
            chk("rr_grant1", m1_ready, (i % 2) == 1);
            adv();
        end
        set_m0(1'b0, 3'b000, 32'h0, 32'h0);
        set_m1(1'b0, 3'b000, 32'h0, 32'h0);
        step();
        step();

        // add wraps modulo 2^32
        set_m0(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h1);
        tick();
        chk("add_accept", m0_ready, 1'b1);
        adv();
        set_m0(1'b0, 3'b001, 32'hABCD_0000, 32'h77);
        tick();
        chk("add_wrap_valid", r0_valid, 1'b1);
        chk("add_wrap_data", r0_data, 32'h0);
        chk("add_wrap_equal", r0_equal, 1'b0);
        adv();

        // unknown op code still completes with zero data
        set_m1(1'b1, 3'b111, 32'd9, 32'd9);
        step();
        set_m1(1'b0, 3'b000, 32'hDEAD, 32'h1);
        tick();
        chk("badop_valid", r1_valid, 1'b1);
        chk("badop_data", r1_data, 32'h0);
        chk("badop_equal", r1_equal, 1'b1);
        adv();

        // port 0 consumer stalls: second request waits, port 1 keeps going
        r0_ready = 1'b0;
        set_m0(1'b1, 3'b011, 32'h5555, 32'h1234);
        set_m1(1'b1, 3'b010, 32'hF0, 32'h0F);
        tick();
        chk("lui_accept", m0_ready, 1'b1);
        adv();
        set_m0(1'b1, 3'b001, 32'd5, 32'd7);
        for (int k = 0; k < 3; k++) begin
            set_m1(1'b1, 3'b000, 32'(k), 32'd100);
            tick();
            chk("stall_m0_ready", m0_ready, 1'b0);
            chk("stall_m1_ready", m1_ready, 1'b1);
            chk("hold_r0_data", r0_data, 32'h1234_0000);
            adv();
        end

        // drain and refill in the same cycle
        r0_ready = 1'b1;
        set_m1(1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        chk("b2b_accept", m0_ready, 1'b1);
        chk("b2b_r0_valid", r0_valid, 1'b1);
        adv();
        r0_ready = 1'b0;
        set_m0(1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        chk("b2b_valid_next", r0_valid, 1'b1);
        chk("b2b_data_next", r0_data, 32'hFFFF_FFFE);
        adv();
        r0_ready = 1'b1;
        step();

        // random traffic with random back-pressure
        for (int i = 0; i < 60; i++) begin
            set_m0(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom());
            set_m1(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom());
            if ($urandom_range(0, 3) == 0) m0_b = m0_a;
            if ($urandom_range(0, 3) == 0) m1_b = m1_a;
            r0_ready = 1'($urandom_range(0, 1));
            r1_ready = 1'($urandom_range(0, 1));
            step();
        end
        set_m0(1'b0, 3'b000, 32'h0, 32'h0);
        set_m1(1'b0, 3'b000, 32'h0, 32'h0);
        r0_ready = 1'b1;
        r1_ready = 1'b1;
        step();
        step();

        // reset with results and requests in flight
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        set_m0(1'b1, 3'b010, 32'h0F00, 32'h00F0);
        set_m1(1'b1, 3'b000, 32'h10, 32'h20);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_m0_ready", m0_ready, 1'b0);
        chk("midrst_m1_ready", m1_ready, 1'b0);
        adv();
        @(negedge clk);
        chk("midrst_r0_valid", r0_valid, 1'b0);
        chk("midrst_r1_valid", r1_valid, 1'b0);
        chk("midrst_r0_data", r0_data, 32'h0);
        chk("midrst_r1_data", r1_data, 32'h0);
        chk("midrst_r0_equal", r0_equal, 1'b0);
        chk("midrst_r1_equal", r1_equal, 1'b0);
        q0.delete();
        q1.delete();
        ptr_m = 1'b0;
        adv();
        reset = 1'b1;
        r0_ready = 1'b1;
        r1_ready = 1'b1;
        tick();
        chk("post_rst_grant0", m0_ready, 1'b1);
        adv();
        step();
        set_m0(1'b0, 3'b000, 32'h0, 32'h0);
        set_m1(1'b0, 3'b000, 32'h0, 32'h0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
